// File: rtl/btn_pkg.sv
// Shared constants for the stopwatch input conditioner: channel indices and default timing.
package btn_pkg;

   localparam int unsigned CH_PAUSE  = 0;
   localparam int unsigned CH_RST    = 1;
   localparam int unsigned CH_SELECT = 2;
   localparam int unsigned CH_ADJUST = 3;
   localparam int unsigned NUM_CH    = 4;

   // 10 ms debounce and 2 s long press at 100 MHz
   localparam int unsigned DB_CYCLES_DEF   = 1_000_000;
   localparam int unsigned LONG_CYCLES_DEF = 200_000_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Board-pin side of the conditioner: raw inputs in, clean control levels/pulses out.
interface btn_conditioner_if;

   logic pause_in;
   logic rst_in;
   logic select_in;
   logic adjust_in;

   logic pause;
   logic rst_req;
   logic select;
   logic adjust;

   // master: the board/stopwatch side that owns the pins and consumes the controls
   modport master (
      output pause_in, rst_in, select_in, adjust_in,
      input  pause, rst_req, select, adjust
   );

   modport slave (
      input  pause_in, rst_in, select_in, adjust_in,
      output pause, rst_req, select, adjust
   );

endinterface

// File: rtl/debounce_channel.sv
// One raw input: 2-FF synchroniser, stable-window debounce counter and edge pulses.
module debounce_channel #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CntW   = $clog2(DB_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

   logic            meta_q;
   logic            sync_q;
   logic            stable_q;
   logic            stable_d;
   logic            stable_dly_q;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // Any cycle where the synced level matches the stable level restarts the window.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q       <= 1'b0;
         sync_q       <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         meta_q       <= raw;
         sync_q       <= meta_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
      end
   end

   assign q    = stable_q;
   assign rise = stable_q & ~stable_dly_q;
   assign fall = ~stable_q & stable_dly_q;

endmodule

// File: rtl/btn_conditioner.sv
// Stopwatch input conditioner: debounced switches, run/pause toggle and one-cycle reset request.
// Define BTN_LONG_PRESS_RST_EN to make a long pause hold issue a reset and toggle on release.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input logic              clk,
   input logic              rst,
   btn_conditioner_if.slave bus
);

   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;

   assign raw[CH_PAUSE]  = bus.pause_in;
   assign raw[CH_RST]    = bus.rst_in;
   assign raw[CH_SELECT] = bus.select_in;
   assign raw[CH_ADJUST] = bus.adjust_in;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw[i]),
         .q    (q[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

   logic pause_q;
   logic pause_d;
   logic rst_req_q;
   logic rst_req_d;
   logic toggle;
   logic long_evt;

`ifdef BTN_LONG_PRESS_RST_EN
   localparam int unsigned      HoldW   = $clog2(LONG_CYCLES + 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

   logic [HoldW-1:0] hold_q;
   logic [HoldW-1:0] hold_d;
   logic             long_q;

   always_comb begin
      hold_d = hold_q;
      if (!q[CH_PAUSE]) begin
         hold_d = '0;
      end else if (hold_q != HoldMax) begin
         hold_d = hold_q + 1'b1;
      end
   end

   // long_q remembers saturation so the long-press event fires once per hold
   assign long_evt = (hold_q == HoldMax) & ~long_q;
   assign toggle   = fall[CH_PAUSE] & (hold_q < HoldMax);

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= (hold_q == HoldMax);
      end
   end
`else
   assign long_evt = 1'b0;
   assign toggle   = rise[CH_PAUSE];
`endif

   always_comb begin
      rst_req_d = (rise[CH_RST] | long_evt) & ~rst_req_q;
      pause_d   = pause_q ^ toggle;
      if (rise[CH_RST] | long_evt) begin
         pause_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pause_q   <= 1'b0;
         rst_req_q <= 1'b0;
      end else begin
         pause_q   <= pause_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign bus.pause   = pause_q;
   assign bus.rst_req = rst_req_q;
   assign bus.select  = q[CH_SELECT];
   assign bus.adjust  = q[CH_ADJUST];

   logic unused_sig;
   assign unused_sig = ^{fall, rise[CH_SELECT], rise[CH_ADJUST], (LONG_CYCLES == 0)};

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DB_CYCLES=4, LONG_CYCLES=20; honours BTN_LONG_PRESS_RST_EN.
module tb_btn_conditioner;

`ifdef BTN_LONG_PRESS_RST_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // expected {pause, rst_req, select, adjust} after each edge
   logic [3:0] sb_q[$];

   btn_conditioner_if bus ();

   btn_conditioner #(
      .DB_CYCLES   (4),
      .LONG_CYCLES (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (vector %0d): got {pause,rst_req,select,adjust}=%b, expected %b",
                  tag, n_vec, got, exp);
      end
   endtask

   // raw = {pause_in, rst_in, select_in, adjust_in}; exp is what must be seen after this edge
   task automatic tick(input logic [3:0] raw, input logic rst_v, input logic [3:0] exp,
                       input string tag, input int t);
      logic [3:0] want;
      {bus.pause_in, bus.rst_in, bus.select_in, bus.adjust_in} = raw;
      rst = rst_v;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq($sformatf("%s t=%0d scoreboard empty", tag, t), 4'bxxxx, 4'b0000);
      end else begin
         want = sb_q.pop_front();
         check_eq($sformatf("%s t=%0d", tag, t),
                  {bus.pause, bus.rst_req, bus.select, bus.adjust}, want);
      end
   endtask

   initial begin
      logic p;
      logic b;

      // reset with random pins: outputs 0 after the first reset edge
      for (int i = 1; i <= 2; i++) tick(4'($urandom_range(0, 15)), 1'b1, 4'b0000, "reset", i);
      for (int i = 1; i <= 6; i++) tick(4'b0000, 1'b0, 4'b0000, "idle", i);

      // bouncing pause press 1,0,1,0 then final 1 (t=1) held for 12 cycles
      for (int i = 0; i < 4; i++) begin
         b = (i % 2 == 0);
         tick({b, 3'b000}, 1'b0, 4'b0000, "bounce_pre", i);
      end
      for (int t = 1; t <= 24; t++) begin
         p = LONG_EN ? (t >= 19) : (t >= 7);
         tick({(t <= 12), 3'b000}, 1'b0, {p, 3'b000}, "bounce", t);
      end

      // 3-cycle select glitch is rejected
      for (int t = 1; t <= 10; t++) tick({2'b00, (t <= 3), 1'b0}, 1'b0, 4'b1000, "glitch", t);

      // clean reset press while paused: one-cycle request and pause cleared on the same edge
      for (int t = 1; t <= 20; t++)
         tick({1'b0, (t <= 10), 2'b00}, 1'b0, {(t < 7), (t == 7), 2'b00}, "rst_req", t);
      for (int t = 1; t <= 16; t++)
         tick({1'b0, (t <= 8), 2'b00}, 1'b0, {1'b0, (t == 7), 2'b00}, "rst_req2", t);

      // adjust switch follows with debounce latency on both edges
      for (int t = 1; t <= 30; t++)
         tick({3'b000, (t <= 20)}, 1'b0, {3'b000, (t >= 6 && t < 26)}, "adjust", t);

      // 30-cycle pause hold
      for (int t = 1; t <= 45; t++) begin
         if (LONG_EN) tick({(t <= 30), 3'b000}, 1'b0, {1'b0, (t == 27), 2'b00}, "long", t);
         else         tick({(t <= 30), 3'b000}, 1'b0, {(t >= 7), 3'b000}, "long", t);
      end

      // pause, rst and select pressed together
      for (int t = 1; t <= 20; t++) begin
         p = LONG_EN ? (t >= 12) : (t < 7);
         tick({(t <= 5), (t <= 5), (t <= 10), 1'b0}, 1'b0,
              {p, (t == 7), (t >= 6 && t < 16), 1'b0}, "simul", t);
      end
      p = LONG_EN;

      // reset in the middle of an adjust debounce, input still held afterwards
      for (int t = 1; t <= 4; t++) tick(4'b0001, 1'b0, {p, 3'b000}, "mid_pre", t);
      tick(4'b0001, 1'b1, 4'b0000, "mid_rst", 0);
      for (int t = 1; t <= 10; t++) tick(4'b0001, 1'b0, {3'b000, (t >= 6)}, "held_at_rst", t);
      for (int t = 1; t <= 8; t++) tick(4'b0000, 1'b0, {3'b000, (t < 6)}, "release", t);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
